// File: rtl/rram_host_pkg.sv
// Shared types and opcode constants for the RRAM host-side FIFO bridge.
package rram_host_pkg;

    localparam int INSTR_W = 20;
    localparam int DATA_W  = 64;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [DATA_W-1:0]  data_t;

    localparam logic [3:0] OP_STORE    = 4'h4;
    localparam logic [3:0] OP_READ     = 4'h5;
    localparam logic [3:0] OP_STORE_HW = 4'h6;

endpackage

// File: rtl/rram_fwft_fifo.sv
// First-word-fall-through circular buffer; head is forced to zero while empty.
module rram_fwft_fifo import rram_host_pkg::*; #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_wr;
    logic             do_rd;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign do_wr     = wr_en & ~full;
    assign do_rd     = rd_en & ~empty;
    assign overflow  = wr_en & full;
    assign underflow = rd_en & empty;
    assign dout      = empty ? '0 : mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rram_host_fifo_bridge.sv
// Host-side buffering for rram_controller_fsm: instruction/data FIFOs toward the
// controller, result FIFO back to the host, plus sticky protocol-error flags.
module rram_host_fifo_bridge import rram_host_pkg::*; #(
    parameter int INSTR_WIDTH   = 4,
    parameter int OPCODE_WIDTH  = 16,
    parameter int DATAIN_WIDTH  = 64,
    parameter int DATAOUT_WIDTH = 64,
    parameter int INST_DEPTH    = 8,
    parameter int DATA_DEPTH    = 16,
    parameter int OUT_DEPTH     = 16
) (
    input  logic                                CLK,
    input  logic                                reset,
    input  logic                                host_instr_valid,
    output logic                                host_instr_ready,
    input  logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] host_instr,
    input  logic                                host_data_valid,
    output logic                                host_data_ready,
    input  logic [DATAIN_WIDTH-1:0]             host_data,
    output logic                                host_res_valid,
    input  logic                                host_res_ready,
    output logic [DATAOUT_WIDTH-1:0]            host_res,
    input  logic                                pop_n_instFIFO,
    output logic                                empty_instFIFO,
    output logic [INSTR_WIDTH+OPCODE_WIDTH-1:0] dout_instFIFO,
    input  logic                                pop_n_iFIFO,
    output logic                                empty_iFIFO,
    output logic [DATAIN_WIDTH-1:0]             dout_iFIFO,
    input  logic                                push_n_oFIFO,
    output logic                                full_oFIFO,
    input  logic [DATAOUT_WIDTH-1:0]            din_oFIFO,
    input  logic                                err_clr,
    output logic                                err_inst_underflow,
    output logic                                err_data_underflow,
    output logic                                err_out_overflow,
    output logic [$clog2(INST_DEPTH):0]         inst_count,
    output logic [$clog2(DATA_DEPTH):0]         data_count,
    output logic [$clog2(OUT_DEPTH):0]          out_count,
    output logic                                idle
);

    logic inst_full, data_full, out_empty;
    logic inst_udf, data_udf, out_ovf;
    logic inst_ovf_unused, data_ovf_unused, out_udf_unused;

    assign host_instr_ready = ~inst_full;
    assign host_data_ready  = ~data_full;
    assign host_res_valid   = ~out_empty;

    rram_fwft_fifo #(.WIDTH(INSTR_WIDTH+OPCODE_WIDTH), .DEPTH(INST_DEPTH)) u_inst_fifo (
        .CLK(CLK), .reset(reset),
        .wr_en(host_instr_valid & host_instr_ready), .rd_en(~pop_n_instFIFO),
        .din(host_instr), .dout(dout_instFIFO),
        .full(inst_full), .empty(empty_instFIFO), .count(inst_count),
        .overflow(inst_ovf_unused), .underflow(inst_udf)
    );

    rram_fwft_fifo #(.WIDTH(DATAIN_WIDTH), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .CLK(CLK), .reset(reset),
        .wr_en(host_data_valid & host_data_ready), .rd_en(~pop_n_iFIFO),
        .din(host_data), .dout(dout_iFIFO),
        .full(data_full), .empty(empty_iFIFO), .count(data_count),
        .overflow(data_ovf_unused), .underflow(data_udf)
    );

    // The controller push is passed raw so the FIFO can flag a push into a full buffer.
    rram_fwft_fifo #(.WIDTH(DATAOUT_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .CLK(CLK), .reset(reset),
        .wr_en(~push_n_oFIFO), .rd_en(host_res_ready & host_res_valid),
        .din(din_oFIFO), .dout(host_res),
        .full(full_oFIFO), .empty(out_empty), .count(out_count),
        .overflow(out_ovf), .underflow(out_udf_unused)
    );

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge CLK) begin
        if (reset) begin
            err_inst_underflow <= 1'b0;
            err_data_underflow <= 1'b0;
            err_out_overflow   <= 1'b0;
        end else begin
            err_inst_underflow <= inst_udf | (err_inst_underflow & ~err_clr);
            err_data_underflow <= data_udf | (err_data_underflow & ~err_clr);
            err_out_overflow   <= out_ovf  | (err_out_overflow   & ~err_clr);
        end
    end

    assign idle = empty_instFIFO & empty_iFIFO & (out_count == '0);

endmodule
